// File: rtl/sc_metadata_arbiter_if.sv
// Bus bundle between the note-metadata requesters, the metadata ROM and the
// arbiter. The arbiter uses the slave modport; the requester/ROM side uses master.
interface sc_metadata_arbiter_if #(
  parameter int PTR_W = 8
);
  logic                 pause;
  logic                 restart;
  logic [36:0]          metadata_request;
  logic                 rom_en;
  logic [6+PTR_W-1:0]   rom_addr;
  logic [15:0]          rom_data;
  logic [37*16-1:0]     metadata_link;
  logic [36:0]          metadata_available;

  modport slave (
    input  pause, restart, metadata_request, rom_data,
    output rom_en, rom_addr, metadata_link, metadata_available
  );

  modport master (
    output pause, restart, metadata_request, rom_data,
    input  rom_en, rom_addr, metadata_link, metadata_available
  );
endinterface

// File: rtl/sc_metadata_arbiter.sv
// Note-metadata fetch arbiter: 37 lanes share one fixed-latency metadata ROM.
// One read per cycle, fully pipelined; each lane keeps its own note pointer
// and a registered copy of the last metadata word fetched for it.
// Build option: define SC_ARB_FIXED_PRIO_EN for fixed priority (lowest lane
// wins); default build is round-robin.
module sc_metadata_arbiter #(
  parameter int ROM_LATENCY = 2,
  parameter int PTR_W       = 8
) (
  input logic                  clk,
  input logic                  reset,
  sc_metadata_arbiter_if.slave bus
);

  localparam int NL = 37;
  localparam int LW = 6;

  logic                  rom_en_q;
  logic [LW+PTR_W-1:0]   rom_addr_q;
  logic [NL*16-1:0]      link_q;
  logic [NL-1:0]         avail_q;
  logic [NL-1:0]         inflight_q;
  logic [PTR_W-1:0]      ptr_q [NL];
  logic [ROM_LATENCY-1:0] pv_q;
  logic [LW-1:0]         pl_q [ROM_LATENCY];

  logic [NL-1:0]         elig;
  logic                  grant_vld;
  logic [LW-1:0]         grant_lane;
  logic [LW-1:0]         start_lane;

`ifdef SC_ARB_FIXED_PRIO_EN
  assign start_lane = '0;
`else
  logic [LW-1:0]         rr_start_q;
  assign start_lane = rr_start_q;
`endif

  assign bus.rom_en             = rom_en_q;
  assign bus.rom_addr           = rom_addr_q;
  assign bus.metadata_link      = link_q;
  assign bus.metadata_available = avail_q;

  // Pick the first eligible lane scanning upward from start_lane with wrap.
  always_comb begin
    logic [6:0] sum;
    logic [5:0] idx;
    sum        = '0;
    idx        = '0;
    grant_vld  = 1'b0;
    grant_lane = '0;
    // A lane whose pulse is showing this cycle sits out one cycle so a
    // requester has time to drop its request.
    elig = bus.metadata_request & ~inflight_q & ~avail_q;
    if (!bus.pause && !bus.restart) begin
      for (int i = 0; i < NL; i++) begin
        sum = {1'b0, start_lane} + 7'(i);
        if (sum >= 7'(NL)) sum = sum - 7'(NL);
        idx = sum[5:0];
        if (!grant_vld && elig[idx]) begin
          grant_vld  = 1'b1;
          grant_lane = idx;
        end
      end
    end
  end

  // Grant issue, read pipeline, completion writeback and pointer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      link_q     <= '0;
      avail_q    <= '0;
      inflight_q <= '0;
      pv_q       <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) pl_q[k] <= '0;
      for (int n = 0; n < NL; n++) ptr_q[n] <= '0;
`ifndef SC_ARB_FIXED_PRIO_EN
      rr_start_q <= '0;
`endif
    end else if (bus.restart) begin
      // Restart wins over pause and over a completion landing this cycle;
      // the link contents are deliberately kept.
      rom_en_q   <= 1'b0;
      avail_q    <= '0;
      inflight_q <= '0;
      pv_q       <= '0;
      for (int n = 0; n < NL; n++) ptr_q[n] <= '0;
`ifndef SC_ARB_FIXED_PRIO_EN
      rr_start_q <= '0;
`endif
    end else begin
      avail_q <= '0;
      // rom_en_q is the issue stage; the shift register then covers the ROM latency.
      pv_q[0] <= rom_en_q;
      pl_q[0] <= rom_addr_q[PTR_W +: LW];
      for (int k = 1; k < ROM_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        pl_q[k] <= pl_q[k-1];
      end
      if (pv_q[ROM_LATENCY-1]) begin
        link_q[{pl_q[ROM_LATENCY-1], 4'b0000} +: 16] <= bus.rom_data;
        avail_q[pl_q[ROM_LATENCY-1]]    <= 1'b1;
        inflight_q[pl_q[ROM_LATENCY-1]] <= 1'b0;
      end
      rom_en_q <= grant_vld;
      if (grant_vld) begin
        rom_addr_q             <= {grant_lane, ptr_q[grant_lane]};
        ptr_q[grant_lane]      <= ptr_q[grant_lane] + 1'b1;
        inflight_q[grant_lane] <= 1'b1;
`ifndef SC_ARB_FIXED_PRIO_EN
        rr_start_q <= (grant_lane == LW'(NL - 1)) ? '0 : grant_lane + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sc_metadata_arbiter.sv
// Self-checking bench for sc_metadata_arbiter (ROM_LATENCY=2, PTR_W=8).
// A ROM model answers reads; a monitor keeps a scoreboard of expected
// completions, per-lane pointers and link contents.
module tb_sc_metadata_arbiter;

  localparam int L     = 2;
  localparam int PTR_W = 8;
  localparam int AW    = 6 + PTR_W;

  logic clk;
  logic rst_n;

  sc_metadata_arbiter_if #(.PTR_W(PTR_W)) bus ();

  sc_metadata_arbiter #(.ROM_LATENCY(L), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic rom_const = 1'b0;

  typedef struct packed {
    logic [5:0]  lane;
    logic [15:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t        exp_q[$];
  logic [AW-1:0] grant_q[$];
  logic [15:0] model_link [37];
  logic [7:0]  model_ptr  [37];

  function automatic logic [15:0] rom_fn(input logic [AW-1:0] a, input logic c);
    rom_fn = c ? 16'hA5A5 : {2'b01, a};
  endfunction

  // ROM model: address captured when rom_en is sampled, data valid L cycles later.
  logic [AW-1:0] rom_stage [L];
  always @(posedge clk) begin
    rom_stage[0] <= bus.rom_addr;
    for (int k = 1; k < L; k++) rom_stage[k] <= rom_stage[k-1];
  end
  assign bus.rom_data = rom_fn(rom_stage[L-1], rom_const);

  // Monitor / scoreboard, sampled 1 time unit after every rising edge.
  always @(posedge clk) begin
    logic [36:0] exp_mask;
    logic        link_bad;
    logic [5:0]  gl;
    exp_t        e;
    cyc = cyc + 1;
    #1;
    exp_mask = '0;
    if (!rst_n || bus.restart) begin
      exp_q.delete();
      for (int l = 0; l < 37; l++) model_ptr[l] = '0;
      if (!rst_n) for (int l = 0; l < 37; l++) model_link[l] = '0;
      n_checks++;
      if (bus.rom_en !== 1'b0 || bus.metadata_available !== 37'd0) begin
        n_fail++;
        $display("FAIL quiet_on_reset_restart cyc=%0d rom_en=%b avail=%h required rom_en=0 avail=0",
                 cyc, bus.rom_en, bus.metadata_available);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due <= 32'(cyc)) begin
        e = exp_q.pop_front();
        exp_mask[e.lane] = 1'b1;
        model_link[e.lane] = e.data;
      end
      n_checks++;
      if (bus.metadata_available !== exp_mask) begin
        n_fail++;
        $display("FAIL available cyc=%0d got=%h required=%h", cyc, bus.metadata_available, exp_mask);
      end
      if (bus.rom_en === 1'b1) begin
        gl = bus.rom_addr[AW-1 -: 6];
        n_checks++;
        if (gl > 6'd36 || bus.rom_addr[PTR_W-1:0] !== model_ptr[gl]) begin
          n_fail++;
          $display("FAIL grant_ptr cyc=%0d addr=%h required_ptr=%h", cyc, bus.rom_addr,
                   (gl > 6'd36) ? 8'h00 : model_ptr[gl]);
        end
        if (gl <= 6'd36) begin
          model_ptr[gl] = model_ptr[gl] + 8'd1;
          exp_q.push_back('{lane: gl, data: rom_fn(bus.rom_addr, rom_const), due: 32'(cyc + L + 1)});
        end
        grant_q.push_back(bus.rom_addr);
      end
    end
    link_bad = 1'b0;
    for (int l = 0; l < 37; l++)
      if (bus.metadata_link[l*16 +: 16] !== model_link[l]) link_bad = 1'b1;
    n_checks++;
    if (link_bad) begin
      n_fail++;
      $display("FAIL link_contents cyc=%0d lane3 got=%h required=%h", cyc,
               bus.metadata_link[63:48], model_link[3]);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk);
    bus.metadata_request = '0;
    bus.pause = 1'b0;
    idle(1);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    grant_q.delete();
  endtask

  task automatic wait_grants(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (grant_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_checks++;
    if (bus.rom_en !== 1'b0 || bus.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_rom got en=%b addr=%h required 0/0", bus.rom_en, bus.rom_addr);
    end
    n_checks++;
    if (bus.metadata_link !== '0 || bus.metadata_available !== '0) begin
      n_fail++;
      $display("FAIL reset_meta got link_nonzero=%b avail=%h required 0", |bus.metadata_link,
               bus.metadata_available);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    bit ok;
    int pulses;
    rom_const = 1'b1;
    grant_q.delete();
    bus.metadata_request[3] = 1'b1;
    wait_grants(1, 5, ok);
    n_checks++;
    if (!ok || grant_q[0] !== {6'd3, 8'd0}) begin
      n_fail++;
      $display("FAIL basic_first_addr got=%h required=%h", ok ? grant_q[0] : '0, {6'd3, 8'd0});
    end
    pulses = 0;
    ok = 1'b0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(negedge clk);
      if (bus.metadata_available[3]) begin
        pulses++;
        n_checks++;
        if (bus.metadata_link[63:48] !== 16'hA5A5) begin
          n_fail++;
          $display("FAIL basic_link got=%h required=a5a5", bus.metadata_link[63:48]);
        end
      end
      if (grant_q.size() >= 2) ok = 1'b1;
    end
    n_checks++;
    if (!ok || pulses != 1) begin
      n_fail++;
      $display("FAIL basic_one_pulse got=%0d required=1 (second grant seen=%0d)", pulses, ok);
    end
    n_checks++;
    if (!ok || grant_q[1] !== {6'd3, 8'd1}) begin
      n_fail++;
      $display("FAIL basic_second_addr got=%h required=%h", ok ? grant_q[1] : '0, {6'd3, 8'd1});
    end
    // Drop the request while the second read is in flight; it must still land.
    bus.metadata_request[3] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.metadata_available[3]) pulses++;
    end
    n_checks++;
    if (pulses != 1 || grant_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_drop_in_flight pulses=%0d grants=%0d required 1/2", pulses, grant_q.size());
    end
    rom_const = 1'b0;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [5:0] lanes3 [3];
    lanes3[0] = 6'd0; lanes3[1] = 6'd5; lanes3[2] = 6'd36;
    do_restart();
    bus.metadata_request[0]  = 1'b1;
    bus.metadata_request[5]  = 1'b1;
    bus.metadata_request[36] = 1'b1;
    wait_grants(9, 40, ok);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (!ok || grant_q[i][AW-1 -: 6] !== lanes3[i % 3]) begin
        n_fail++;
        $display("FAIL rr3_order idx=%0d got=%0d required=%0d", i, ok ? grant_q[i][AW-1 -: 6] : 6'd63,
                 lanes3[i % 3]);
      end
    end
    do_restart();
    bus.metadata_request = '1;
    wait_grants(12, 30, ok);
    for (int i = 0; i < 12; i++) begin
      logic [5:0] want;
`ifdef SC_ARB_FIXED_PRIO_EN
      want = 6'(i % 5);
`else
      want = 6'(i);
`endif
      n_checks++;
      if (!ok || grant_q[i][AW-1 -: 6] !== want) begin
        n_fail++;
        $display("FAIL all_lanes_order idx=%0d got=%0d required=%0d", i,
                 ok ? grant_q[i][AW-1 -: 6] : 6'd63, want);
      end
    end
    bus.metadata_request = '0;
    idle(8);
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_restart();
    bus.metadata_request[7] = 1'b1;
    wait_grants(257, 2000, ok);
    n_checks++;
    if (!ok || grant_q[255] !== {6'd7, 8'd255}) begin
      n_fail++;
      $display("FAIL ptr_255 got=%h required=%h", ok ? grant_q[255] : '0, {6'd7, 8'd255});
    end
    n_checks++;
    if (!ok || grant_q[256] !== {6'd7, 8'd0}) begin
      n_fail++;
      $display("FAIL ptr_wrap got=%h required=%h", ok ? grant_q[256] : '0, {6'd7, 8'd0});
    end
    bus.metadata_request = '0;
    idle(8);
  endtask

  task automatic test_pause();
    bit ok;
    int p1, p2;
    do_restart();
    bus.metadata_request[1] = 1'b1;
    bus.metadata_request[2] = 1'b1;
    wait_grants(2, 5, ok);
    bus.pause = 1'b1;
    p1 = 0; p2 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.metadata_available[1]) p1++;
      if (bus.metadata_available[2]) p2++;
    end
    n_checks++;
    if (!ok || p1 != 1 || p2 != 1) begin
      n_fail++;
      $display("FAIL pause_pulses got=%0d/%0d required=1/1", p1, p2);
    end
    n_checks++;
    if (grant_q.size() != 2) begin
      n_fail++;
      $display("FAIL pause_no_grant got=%0d grants required=2", grant_q.size());
    end
    bus.pause = 1'b0;
    wait_grants(3, 5, ok);
    n_checks++;
    if (!ok || grant_q[2] !== {6'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL pause_resume_addr got=%h required=%h", ok ? grant_q[2] : '0, {6'd1, 8'd1});
    end
    bus.metadata_request = '0;
    idle(8);
  endtask

  task automatic test_restart();
    bit ok;
    int pulses;
    logic [37*16-1:0] link_before;
    do_restart();
    bus.metadata_request[1] = 1'b1;
    bus.metadata_request[2] = 1'b1;
    wait_grants(2, 5, ok);
    link_before = bus.metadata_link;
    bus.metadata_request = '0;
    @(negedge clk);
    // Restart lands on the same edge as lane 1's completion.
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.metadata_available !== '0) pulses++;
    end
    n_checks++;
    if (!ok || pulses != 0) begin
      n_fail++;
      $display("FAIL restart_no_pulse got=%0d pulsing cycles required=0", pulses);
    end
    n_checks++;
    if (bus.metadata_link !== link_before) begin
      n_fail++;
      $display("FAIL restart_link_hold lane1 got=%h required=%h", bus.metadata_link[31:16],
               link_before[31:16]);
    end
    grant_q.delete();
    bus.metadata_request[1] = 1'b1;
    bus.metadata_request[2] = 1'b1;
    wait_grants(2, 5, ok);
    n_checks++;
    if (!ok || grant_q[0] !== {6'd1, 8'd0} || grant_q[1] !== {6'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL restart_ptr_zero got=%h,%h required=%h,%h", ok ? grant_q[0] : '0,
               ok ? grant_q[1] : '0, {6'd1, 8'd0}, {6'd2, 8'd0});
    end
    bus.metadata_request = '0;
    idle(8);
  endtask

  task automatic test_async_reset();
    bit ok;
    int pulses;
    do_restart();
    bus.metadata_request[4] = 1'b1;
    bus.metadata_request[6] = 1'b1;
    wait_grants(2, 5, ok);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || bus.rom_en !== 1'b0 || bus.rom_addr !== '0 || bus.metadata_available !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs got en=%b addr=%h avail=%h required 0", bus.rom_en,
               bus.rom_addr, bus.metadata_available);
    end
    n_checks++;
    if (bus.metadata_link !== '0) begin
      n_fail++;
      $display("FAIL async_reset_link got lane1=%h required=0", bus.metadata_link[31:16]);
    end
    bus.metadata_request = '0;
    idle(2);
    rst_n = 1'b1;
    grant_q.delete();
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.metadata_available !== '0) pulses++;
    end
    n_checks++;
    if (pulses != 0 || grant_q.size() != 0) begin
      n_fail++;
      $display("FAIL async_reset_quiet pulses=%0d grants=%0d required 0/0", pulses, grant_q.size());
    end
    bus.metadata_request[4] = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== {6'd4, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset_first_grant got en=%b addr=%h required 1/%h", bus.rom_en,
               bus.rom_addr, {6'd4, 8'd0});
    end
    bus.metadata_request = '0;
    idle(8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.pause = 1'b0;
    bus.restart = 1'b0;
    bus.metadata_request = '0;
    for (int l = 0; l < 37; l++) begin
      model_link[l] = '0;
      model_ptr[l]  = '0;
    end
    test_reset();
    test_basic();
    test_round_robin();
    test_back_to_back();
    test_pause();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_metadata_arbiter.md
SC_METADATA_ARBITER -- requirements
Module: sc_metadata_arbiter

Interface
REQ-001 Parameter: ROM_LATENCY, 2, fixed cycles from rom_en sample to valid rom_data (legal range 1..4).
REQ-002 Parameter: PTR_W, 8, width of each lane's note pointer.
REQ-003 Port: clk  in  1  100 MHz system clock; the block's only clock.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: pause  in  1  game paused; no new grants.
REQ-006 Port: restart  in  1  synchronous song restart pulse.
REQ-007 Port: metadata_request  in  37  per-lane level request for the next note's metadata.
REQ-008 Port: rom_en  out  1  metadata ROM read strobe.
REQ-009 Port: rom_addr  out  6+PTR_W  ROM address {lane[5:0], ptr[PTR_W-1:0]}.
REQ-010 Port: rom_data  in  16  ROM read data, valid ROM_LATENCY cycles after rom_en.
REQ-011 Port: metadata_link  out  37*16  per-lane registered metadata; lane i at bits [16i+15:16i].
REQ-012 Port: metadata_available  out  37  per-lane one-cycle pulse: metadata_link lane updated.

Function
REQ-013 Eligible lane: request=1, no read in flight for that lane, and metadata_available for that lane not asserted this cycle.
REQ-014 Each cycle with pause=0, restart=0 and at least one eligible lane, exactly one lane is granted: rom_en=1, rom_addr={lane, ptr[lane]}, registered outputs.
REQ-015 Arbitration is round-robin: search starts at lane (last_grant+1) mod 37, wrapping 36->0; after reset the search starts at lane 0.
REQ-016 Grant marks the lane in flight and increments ptr[lane] modulo 2^PTR_W (255 wraps to 0 at PTR_W=8).
REQ-017 Read pipeline: valid/lane shift register of depth ROM_LATENCY; one read issued per cycle, fully pipelined.
REQ-018 On pipeline exit, rom_data is written to metadata_link[lane], metadata_available[lane] pulses for exactly one cycle, and the in-flight bit clears in the same cycle.
REQ-019 Issue-to-available latency: ROM_LATENCY+1 cycles from the grant's request-sampling edge.
REQ-020 metadata_link lane holds its value until that lane's next completion.
REQ-021 Requester handshake: a request held high after an available pulse is treated as a new request; a requester drops request no later than the cycle after the pulse to avoid a further fetch.
REQ-022 pause=1: no new grants; in-flight reads complete and pulse normally; pointers hold.
REQ-023 restart=1: all pointers clear to 0, all in-flight reads are discarded (no available pulse, no link update), in-flight bits clear, no grant that cycle; metadata_link holds; round-robin start returns to lane 0.
REQ-024 restart has priority over pause and over a simultaneous pipeline completion.
REQ-025 Request deasserted while in flight: the read still completes and pulses.

Reset
REQ-026 reset=0 asynchronously clears: rom_en=0, rom_addr=0, metadata_available=0, metadata_link=0, all pointers, in-flight bits, pipeline valids, and the round-robin pointer.
REQ-027 Reset asserted mid-operation discards all in-flight reads; after deassertion the first grant occurs on the first clock edge with an eligible lane.

Configuration
REQ-028 Macro SC_ARB_FIXED_PRIO_EN defined: fixed priority, lowest-numbered eligible lane wins, round-robin pointer not implemented.
REQ-029 Macro SC_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015.

Verification
REQ-030 Reset release, request[3]=1 held, rom_data=16'hA5A5 -> rom_addr={6'd3,8'd0}, 3 cycles later metadata_link[63:48]=A5A5 and available[3] pulses once; next grant uses ptr 1.
REQ-031 request[0],[5],[36] all high continuously -> grant order 0,5,36,0,5,36... (round-robin); fixed-priority build -> lane 0 granted whenever eligible.
REQ-032 Lane 7 fetched 256 times at PTR_W=8 -> 257th rom_addr={6'd7,8'd0}.
REQ-033 pause=1 with 2 reads in flight -> both available pulses occur, rom_en stays 0 until pause=0.
REQ-034 restart pulse with 2 reads in flight -> no available pulses, link unchanged, next grant for each lane uses ptr 0.
REQ-035 reset=0 asserted mid-pipeline, asynchronous to clk -> all outputs 0 immediately, no pulses after release until a new grant.
